// File: rtl/spw_pkg.sv
// spw_pkg: shared constants and FCT request FSM encoding for the SpaceWire receive path
package spw_pkg;
  localparam int FCT_CREDIT = 8;
  localparam int MAX_CREDIT = 56;
  localparam int NCHAR_WIDTH = 9;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ = 1'b1;
endpackage

// File: rtl/spw_sync_fifo.sv
// spw_sync_fifo: single-clock FIFO with registered read data, wrapping pointers and occupancy count
// Ports: clk/rst_n (async active-low), wr_en/wr_data write side, rd_en/rd_data/rd_valid read side
// (one-cycle read latency), empty/full/count occupancy status.
module spw_sync_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_WIDTH = spw_pkg::NCHAR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int CW = DEPTH_LOG2 + 1;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  // full is sampled before any same-cycle read, so a write into a full FIFO is always refused
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign full  = count[DEPTH_LOG2];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + DEPTH_LOG2'(wr_ok);
      rd_ptr   <= rd_ptr + DEPTH_LOG2'(rd_ok);
      count    <= count + CW'(wr_ok) - CW'(rd_ok);
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rd_ptr];
    end
endmodule

// File: rtl/spw_rx_credit_fifo.sv
// spw_rx_credit_fifo: SpaceWire receive buffer with FCT credit tracking and request handshake
// Ports: pclk/resetn (async active-low); link_fct_enable gates FCTs; rx_data_flag/rx_buffer_write
// deliver N-chars; fct_done/send_fct_now form the FCT handshake; credit_error flags a violation;
// rd_en/rd_data/rd_valid is the host read port; fifo_*/credit_count expose occupancy and credit.
module spw_rx_credit_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_WIDTH = spw_pkg::NCHAR_WIDTH,
  parameter int FCT_CREDIT = spw_pkg::FCT_CREDIT,
  parameter int MAX_CREDIT = spw_pkg::MAX_CREDIT
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic                  link_fct_enable,
  input  logic [DATA_WIDTH-1:0] rx_data_flag,
  input  logic                  rx_buffer_write,
  input  logic                  fct_done,
  output logic                  send_fct_now,
  output logic                  credit_error,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [5:0]            credit_count
);
  localparam int CW = DEPTH_LOG2 + 1;
  logic [0:0] state;
  logic wr_ok, fct_ok;
  logic [CW-1:0] need, free_space;
  assign wr_ok = rx_buffer_write && credit_count != '0 && !fifo_full;
  // a new FCT must fit both the protocol ceiling and the space not already promised to the peer
  assign need       = CW'(credit_count) + CW'(FCT_CREDIT);
  assign free_space = CW'(2**DEPTH_LOG2) - fifo_count;
  assign fct_ok     = link_fct_enable && need <= CW'(MAX_CREDIT) && free_space >= need;
  assign send_fct_now = state == spw_pkg::REQ;
  always_ff @(posedge pclk or negedge resetn)
    if (!resetn) begin
      state        <= spw_pkg::IDLE;
      credit_count <= '0;
      credit_error <= 1'b0;
    end else begin
      credit_error <= rx_buffer_write && !wr_ok;
      if (!link_fct_enable) begin
        state        <= spw_pkg::IDLE;
        credit_count <= '0;
      end else if (state == spw_pkg::REQ && fct_done) begin
        state        <= spw_pkg::IDLE;
        credit_count <= credit_count + 6'(FCT_CREDIT) - 6'(wr_ok);
      end else begin
        state        <= state == spw_pkg::IDLE && fct_ok ? spw_pkg::REQ : state;
        credit_count <= credit_count - 6'(wr_ok);
      end
    end
  spw_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk(pclk),
    .rst_n(resetn),
    .wr_en(wr_ok),
    .wr_data(rx_data_flag),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(fifo_empty),
    .full(fifo_full),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_spw_rx_credit_fifo.sv
// tb_spw_rx_credit_fifo: table-driven and directed checks of the receive credit FIFO
module tb_spw_rx_credit_fifo;
  logic pclk = 1'b0;
  logic resetn = 1'b1;
  logic link_fct_enable = 1'b0;
  logic rx_buffer_write = 1'b0;
  logic fct_done = 1'b0;
  logic rd_en = 1'b0;
  logic [8:0] rx_data_flag = '0;
  logic send_fct_now, credit_error, rd_valid, fifo_empty, fifo_full;
  logic [8:0] rd_data;
  logic [6:0] fifo_count;
  logic [5:0] credit_count;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic en, wr, done, rd;
    logic [8:0] d;
    logic e_send, e_err, e_rv;
    int e_cred, e_cnt;
    logic [8:0] e_rd;
  } vec_t;
  vec_t vq[$];
  always #5 pclk = ~pclk;
  spw_rx_credit_fifo dut (
    .pclk(pclk),
    .resetn(resetn),
    .link_fct_enable(link_fct_enable),
    .rx_data_flag(rx_data_flag),
    .rx_buffer_write(rx_buffer_write),
    .fct_done(fct_done),
    .send_fct_now(send_fct_now),
    .credit_error(credit_error),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .credit_count(credit_count)
  );
  function automatic vec_t mk(input logic en, wr, input int d, input logic done, rd, e_send,
                              input int e_cred, e_cnt, input logic e_err, e_rv, input int e_rd);
    vec_t v;
    v.en = en; v.wr = wr; v.d = 9'(d); v.done = done; v.rd = rd;
    v.e_send = e_send; v.e_cred = e_cred; v.e_cnt = e_cnt;
    v.e_err = e_err; v.e_rv = e_rv; v.e_rd = 9'(e_rd);
    return v;
  endfunction
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask
  task automatic chk_row(input int i, input vec_t v);
    chk("send_fct_now", i, 32'(send_fct_now), 32'(v.e_send));
    chk("credit_count", i, 32'(credit_count), v.e_cred);
    chk("fifo_count", i, 32'(fifo_count), v.e_cnt);
    chk("credit_error", i, 32'(credit_error), 32'(v.e_err));
    chk("rd_valid", i, 32'(rd_valid), 32'(v.e_rv));
    chk("fifo_empty", i, 32'(fifo_empty), 32'(v.e_cnt == 0));
    chk("fifo_full", i, 32'(fifo_full), 32'(v.e_cnt == 64));
    if (v.e_rv) chk("rd_data", i, 32'(rd_data), 32'(v.e_rd));
  endtask
  initial begin
    int widx, err_seen;
    // grant 7 FCTs from zero credit, each answered in the second cycle of the request
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int j = 1; j <= 7; j++) begin
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 8 * (j - 1), 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 1, 0, 0, 8 * j, 0, 0, 0, 0));
      if (j < 7) vq.push_back(mk(1, 0, 0, 0, 0, 1, 8 * j, 0, 0, 0, 0));
    end
    for (int j = 0; j < 3; j++) vq.push_back(mk(1, 0, 0, 0, 0, 0, 56, 0, 0, 0, 0));
    // 8 writes from full credit; 48 credit and 8 stored leaves room for exactly one more FCT
    for (int k = 1; k <= 8; k++) vq.push_back(mk(1, 1, 'h040 + k, 0, 0, 0, 56 - k, k, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 48, 8, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 56, 8, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 56, 8, 0, 0, 0));
    for (int k = 1; k <= 8; k++) vq.push_back(mk(1, 0, 0, 0, 1, 0, 56, 8 - k, 0, 1, 'h040 + k));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 56, 0, 0, 0, 0));
    // link disable zeroes credit; a write at zero credit is dropped and flagged
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 'h1FF, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // fct_done while IDLE is ignored even as the request starts
    vq.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 8, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 16, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 16, 0, 0, 0, 0));
    // writes during REQ bring credit to 10, then fct_done with a write gives 17
    for (int k = 0; k < 6; k++) vq.push_back(mk(1, 1, 'h100 + k, 0, 0, 1, 15 - k, k + 1, 0, 0, 0));
    vq.push_back(mk(1, 1, 'h106, 1, 0, 0, 17, 7, 0, 0, 0));
    // disable while requesting; the late fct_done is ignored and data survives
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 17, 7, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 7, 0, 0, 0));
    for (int k = 1; k <= 7; k++) vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 7 - k, 0, 1, 'h0FF + k));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #2 resetn = 1'b0;
    #10;
    chk("rst_send", 0, 32'(send_fct_now), 0);
    chk("rst_credit", 0, 32'(credit_count), 0);
    chk("rst_count", 0, 32'(fifo_count), 0);
    chk("rst_empty", 0, 32'(fifo_empty), 1);
    chk("rst_full", 0, 32'(fifo_full), 0);
    chk("rst_err", 0, 32'(credit_error), 0);
    chk("rst_rvalid", 0, 32'(rd_valid), 0);
    chk("rst_rdata", 0, 32'(rd_data), 0);
    tick();
    resetn = 1'b1;
    foreach (vq[i]) begin
      link_fct_enable = vq[i].en;
      rx_buffer_write = vq[i].wr;
      rx_data_flag    = vq[i].d;
      fct_done        = vq[i].done;
      rd_en           = vq[i].rd;
      tick();
      chk_row(i, vq[i]);
    end
    // fill all 64 entries, granting each request on the cycle it is seen
    widx = 0;
    err_seen = 0;
    for (int c = 0; c < 600 && widx < 64; c++) begin
      link_fct_enable = 1'b1;
      rd_en = 1'b0;
      fct_done = send_fct_now;
      rx_buffer_write = credit_count != 0 && !fifo_full;
      rx_data_flag = 9'('h080 + widx);
      if (rx_buffer_write) widx++;
      tick();
      if (credit_error) err_seen++;
    end
    rx_buffer_write = 1'b0;
    fct_done = 1'b0;
    chk("fill_count", 0, 32'(fifo_count), 64);
    chk("fill_full", 0, 32'(fifo_full), 1);
    chk("fill_empty", 0, 32'(fifo_empty), 0);
    chk("fill_credit", 0, 32'(credit_count), 0);
    chk("fill_send", 0, 32'(send_fct_now), 0);
    chk("fill_errs", 0, err_seen, 0);
    rx_buffer_write = 1'b1;
    rx_data_flag = 9'h1AA;
    tick();
    chk("full_wr_err", 0, 32'(credit_error), 1);
    chk("full_wr_count", 0, 32'(fifo_count), 64);
    rx_buffer_write = 1'b0;
    tick();
    chk("full_err_clear", 0, 32'(credit_error), 0);
    rx_buffer_write = 1'b1;
    rx_data_flag = 9'h155;
    rd_en = 1'b1;
    tick();
    chk("rw_full_rvalid", 0, 32'(rd_valid), 1);
    chk("rw_full_rdata", 0, 32'(rd_data), 'h080);
    chk("rw_full_count", 0, 32'(fifo_count), 63);
    chk("rw_full_err", 0, 32'(credit_error), 1);
    chk("rw_full_full", 0, 32'(fifo_full), 0);
    rx_buffer_write = 1'b0;
    for (int k = 1; k < 64; k++) begin
      tick();
      chk("drain_rvalid", k, 32'(rd_valid), 1);
      chk("drain_rdata", k, 32'(rd_data), 'h080 + k);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_count", 0, 32'(fifo_count), 0);
    chk("drain_empty", 0, 32'(fifo_empty), 1);
    chk("drain_rvalid_low", 0, 32'(rd_valid), 0);
    chk("drain_send", 0, 32'(send_fct_now), 1);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_send", 0, 32'(send_fct_now), 0);
    chk("async_rst_empty", 0, 32'(fifo_empty), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
